// File: rtl/tile_cmd_sched.sv
// Tile command scheduler: decodes released-key events into tile commands,
// queues them in a small FIFO, and applies them to a 10-entry colour
// register file only while the display is blanked.
module tile_cmd_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       flag,
  input  logic       blank,
  input  logic [3:0] rd_idx,
  output logic [8:0] rd_color,
  output logic [3:0] sel,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CMD_SEL, CMD_SET, CMD_ROT, CMD_INV} cmd_kind_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic [8:0] data;   // tile index in [3:0] for SELECT, colour for SET
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_INV} state_e;

  // Storage
  logic [8:0]    r_tile [10];
  cmd_t          r_mem  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_sel;
  logic [8:0]    r_tmp;
  logic [3:0]    r_step;
  logic          r_overflow;
  state_e        r_state;

  // Combinational control
  logic       w_dec_valid;
  cmd_t       w_dec_cmd;
  cmd_t       w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  state_e     w_next;
  logic       w_we;
  logic [3:0] w_waddr;
  logic [8:0] w_wdata;
  logic       w_sel_load;
  logic       w_tmp_load;
  logic       w_step_clr;
  logic       w_step_inc;

  assign w_full   = (r_count == DEPTH[AW:0]);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rptr];
  // A full queue still accepts a command when the head leaves in the same cycle.
  assign w_push   = w_dec_valid && (!w_full || w_pop);

  assign sel      = r_sel;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;

  // Decode a released-key strobe into a command; unknown codes are dropped.
  always_comb begin
    w_dec_valid = 1'b0;
    w_dec_cmd   = '0;
    if (flag) begin
      w_dec_valid = 1'b1;
      case (scancode)
        8'h45:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd0};
        8'h16:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd1};
        8'h1E:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd2};
        8'h26:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd3};
        8'h25:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd4};
        8'h2E:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd5};
        8'h36:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd6};
        8'h3D:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd7};
        8'h3E:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd8};
        8'h46:   w_dec_cmd = '{kind: CMD_SEL, data: 9'd9};
        8'h2D:   w_dec_cmd = '{kind: CMD_SET, data: 9'b111000000};
        8'h34:   w_dec_cmd = '{kind: CMD_SET, data: 9'b000111000};
        8'h32:   w_dec_cmd = '{kind: CMD_SET, data: 9'b000000111};
        8'h1C:   w_dec_cmd = '{kind: CMD_SET, data: 9'h1FF};
        8'h3A:   w_dec_cmd = '{kind: CMD_SET, data: 9'h000};
        8'h21:   w_dec_cmd = '{kind: CMD_ROT, data: 9'd0};
        8'h43:   w_dec_cmd = '{kind: CMD_INV, data: 9'd0};
        default: w_dec_valid = 1'b0;
      endcase
    end
  end

  // FIFO payload storage (no reset needed; validity is tracked by r_count).
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec_cmd;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag: a valid command was lost to a full queue.
  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else if (w_dec_valid && w_full && !w_pop) r_overflow <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state, queue pop and the single tile write port.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_we       = 1'b0;
    w_waddr    = '0;
    w_wdata    = '0;
    w_sel_load = 1'b0;
    w_tmp_load = 1'b0;
    w_step_clr = 1'b0;
    w_step_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          case (w_head.kind)
            CMD_SEL: begin
              w_pop      = 1'b1;
              w_sel_load = 1'b1;
            end
            CMD_SET: if (blank) begin
              w_pop   = 1'b1;
              w_we    = 1'b1;
              w_waddr = r_sel;
              w_wdata = w_head.data;
            end
            CMD_ROT: if (blank) begin
              w_pop      = 1'b1;
              w_tmp_load = 1'b1;
              w_step_clr = 1'b1;
              w_next     = S_ROT;
            end
            default: if (blank) begin
              w_pop      = 1'b1;
              w_step_clr = 1'b1;
              w_next     = S_INV;
            end
          endcase
        end
      end
      S_ROT: begin
        // Ring walk 4<-7<-8<-9<-6<-3<-2<-1<-tmp, one tile per cycle.
        w_we       = 1'b1;
        w_step_inc = 1'b1;
        case (r_step[2:0])
          3'd0:    begin w_waddr = 4'd4; w_wdata = r_tile[7]; end
          3'd1:    begin w_waddr = 4'd7; w_wdata = r_tile[8]; end
          3'd2:    begin w_waddr = 4'd8; w_wdata = r_tile[9]; end
          3'd3:    begin w_waddr = 4'd9; w_wdata = r_tile[6]; end
          3'd4:    begin w_waddr = 4'd6; w_wdata = r_tile[3]; end
          3'd5:    begin w_waddr = 4'd3; w_wdata = r_tile[2]; end
          3'd6:    begin w_waddr = 4'd2; w_wdata = r_tile[1]; end
          default: begin w_waddr = 4'd1; w_wdata = r_tmp;     end
        endcase
        if (r_step == 4'd7) w_next = S_IDLE;
      end
      S_INV: begin
        w_we       = 1'b1;
        w_step_inc = 1'b1;
        w_waddr    = r_step + 4'd1;
        w_wdata    = ~r_tile[w_waddr];
        if (r_step == 4'd8) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sequence step counter and rotate scratch register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step <= '0;
      r_tmp  <= '0;
    end else begin
      if (w_step_clr)      r_step <= '0;
      else if (w_step_inc) r_step <= r_step + 4'd1;
      if (w_tmp_load) r_tmp <= r_tile[4];
    end
  end

  // Selected tile register.
  always_ff @(posedge clk) begin
    if (reset)           r_sel <= '0;
    else if (w_sel_load) r_sel <= w_head.data[3:0];
  end

  // Tile colour register file, one write per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < 10; k++) r_tile[k] <= '0;
    end else if (w_we) begin
      r_tile[w_waddr] <= w_wdata;
    end
  end

  // Combinational read port for the pixel path.
  always_comb begin
    rd_color = '0;
    if (rd_idx <= 4'd9) rd_color = r_tile[rd_idx];
  end

endmodule

// File: tb/tb_tile_cmd_sched.sv
// Directed bench for tile_cmd_sched: table-driven reset/select/set vectors
// plus hand-written sequences for rotate, invert, blocking, overflow, reset.
module tb_tile_cmd_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scancode;
  logic       flag;
  logic       blank;
  logic [3:0] rd_idx;
  logic [8:0] rd_color;
  logic [3:0] sel;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  tile_cmd_sched #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .scancode (scancode),
    .flag     (flag),
    .blank    (blank),
    .rd_idx   (rd_idx),
    .rd_color (rd_color),
    .sel      (sel),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        send;
    logic [7:0]  code;
    logic        blank;
    int unsigned waitc;
    logic [3:0]  idx;
    logic [8:0]  exp_color;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] pre_a [10] = '{8'h45, 8'h2D, 8'h16, 8'h2D, 8'h1E, 8'h34, 8'h26, 8'h32, 8'h25, 8'h1C};
  logic [7:0] pre_b [10] = '{8'h36, 8'h2D, 8'h46, 8'h34, 8'h3E, 8'h32, 8'h3D, 8'h1C, 8'h2E, 8'h3A};
  logic [7:0] fill4 [4]  = '{8'h2D, 8'h34, 8'h32, 8'h1C};

  // Hand-derived tile contents after preload, after ROTATE, after INVERT.
  logic [8:0] e_pre [10] = '{9'h1C0, 9'h03F, 9'h1C7, 9'h1F8, 9'h000, 9'h000, 9'h1C0, 9'h1FF, 9'h007, 9'h038};
  logic [8:0] e_rot [10] = '{9'h1C0, 9'h000, 9'h03F, 9'h1C7, 9'h1FF, 9'h000, 9'h1F8, 9'h007, 9'h038, 9'h1C0};
  logic [8:0] e_inv [10] = '{9'h1C0, 9'h1FF, 9'h1C0, 9'h038, 9'h000, 9'h1FF, 9'h007, 9'h1F8, 9'h1C7, 9'h03F};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] code);
    @(negedge clk);
    scancode = code;
    flag     = 1'b1;
    @(negedge clk);
    flag     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flag  = 1'b0;
    blank = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_tile(input string name, input logic [3:0] idx, input logic [8:0] exp);
    rd_idx = idx;
    #1;
    chk(name, 16'(rd_color), 16'(exp));
  endtask

  task automatic count_busy(input string name, input int unsigned exp);
    int unsigned n;
    n = 0;
    chk({name, "_start"}, 16'(busy), 16'd0);
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (busy) n++;
    end
    chk({name, "_cycles"}, 16'(n), 16'(exp));
  endtask

  initial begin
    reset    = 1'b1;
    flag     = 1'b0;
    blank    = 1'b0;
    scancode = '0;
    rd_idx   = '0;
    tick(2);
    reset    = 1'b0;

    // Reset state, then SELECT tile 1 and SET red with exact latency.
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 4'(i), 9'h000, 4'd0});
    vecs.push_back('{1'b1, 8'h16, 1'b1, 0, 4'd1, 9'h000, 4'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 4'd1, 9'h000, 4'd1});
    vecs.push_back('{1'b1, 8'h2D, 1'b1, 0, 4'd1, 9'h000, 4'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 4'd1, 9'h1C0, 4'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 4'd0, 9'h000, 4'd1});
    for (int i = 2; i < 10; i++)
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 4'(i), 9'h000, 4'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 4'd13, 9'h000, 4'd1});

    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    foreach (vecs[i]) begin
      blank = vecs[i].blank;
      if (vecs[i].send) send(vecs[i].code);
      tick(vecs[i].waitc);
      rd_idx = vecs[i].idx;
      #1;
      chk($sformatf("vec%0d_color", i), 16'(rd_color), 16'(vecs[i].exp_color));
      chk($sformatf("vec%0d_sel", i), 16'(sel), 16'(vecs[i].exp_sel));
    end

    // Preload distinct ring values using SET, INVERT, SET.
    blank = 1'b1;
    foreach (pre_a[i]) send(pre_a[i]);
    send(8'h43);
    tick(14);
    chk("pre_inv_idle", 16'(busy), 16'd0);
    foreach (pre_b[i]) send(pre_b[i]);
    tick(3);
    for (int k = 0; k < 10; k++) chk_tile($sformatf("pre_t%0d", k), 4'(k), e_pre[k]);

    // ROTATE: eight busy cycles, clockwise ring shift.
    send(8'h21);
    count_busy("rot_busy", 8);
    for (int k = 0; k < 10; k++) chk_tile($sformatf("rot_t%0d", k), 4'(k), e_rot[k]);

    // INVERT: nine busy cycles, tiles 1..9 complemented.
    send(8'h43);
    count_busy("inv_busy", 9);
    for (int k = 0; k < 10; k++) chk_tile($sformatf("inv_t%0d", k), 4'(k), e_inv[k]);

    // Head-of-line blocking while visible, then ordered drain on blank.
    do_reset();
    blank = 1'b0;
    send(8'h16);
    send(8'h2D);
    send(8'h1E);
    send(8'h34);
    tick(4);
    chk("hol_sel", 16'(sel), 16'd1);
    chk_tile("hol_t1", 4'd1, 9'h000);
    chk_tile("hol_t2", 4'd2, 9'h000);
    tick(1);
    blank = 1'b1;
    tick(1);
    chk_tile("drain1_t1", 4'd1, 9'h1C0);
    chk("drain1_sel", 16'(sel), 16'd1);
    tick(1);
    chk("drain2_sel", 16'(sel), 16'd2);
    chk_tile("drain2_t2", 4'd2, 9'h000);
    tick(1);
    chk_tile("drain3_t2", 4'd2, 9'h038);

    // DEPTH+1 SETs while visible: last one dropped, overflow sticks.
    do_reset();
    blank = 1'b0;
    rd_idx = 4'd0;
    foreach (fill4[i]) begin
      @(negedge clk);
      scancode = fill4[i];
      flag     = 1'b1;
    end
    @(negedge clk);
    scancode = 8'h3A;
    flag     = 1'b1;
    #1;
    chk("ovf_before", 16'(overflow), 16'd0);
    @(negedge clk);
    flag = 1'b0;
    #1;
    chk("ovf_set", 16'(overflow), 16'd1);
    chk_tile("ovf_blocked_t0", 4'd0, 9'h000);
    tick(2);
    blank = 1'b1;
    tick(8);
    chk_tile("ovf_drain_t0", 4'd0, 9'h1FF);
    chk("ovf_hold", 16'(overflow), 16'd1);

    // Full queue with a simultaneous pop accepts the new command.
    do_reset();
    blank = 1'b0;
    foreach (fill4[i]) begin
      @(negedge clk);
      scancode = fill4[i];
      flag     = 1'b1;
    end
    @(negedge clk);
    scancode = 8'h3A;
    flag     = 1'b1;
    blank    = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    tick(8);
    chk("fullpop_ovf", 16'(overflow), 16'd0);
    chk_tile("fullpop_t0", 4'd0, 9'h000);

    // Reset in the middle of a rotate.
    do_reset();
    blank = 1'b1;
    send(8'h16);
    send(8'h2D);
    tick(2);
    chk_tile("mid_pre_t1", 4'd1, 9'h1C0);
    send(8'h21);
    tick(4);
    chk("mid_busy", 16'(busy), 16'd1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_sel", 16'(sel), 16'd0);
    for (int k = 0; k < 10; k++) chk_tile($sformatf("mid_rst_t%0d", k), 4'(k), 9'h000);
    reset = 1'b0;
    tick(10);
    chk("mid_after_busy", 16'(busy), 16'd0);
    chk_tile("mid_after_t1", 4'd1, 9'h000);
    chk_tile("mid_after_t4", 4'd4, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
